// File: rtl/add_sub_cla_pipe_if.sv
// Handshake and data bundle for the pipelined CLA adder/subtractor.
// The master side drives operands and result-ready; the slave side is the datapath.
interface add_sub_cla_pipe_if #(
    parameter int DATA_W = 24
);
    logic              i_valid;
    logic              o_ready;
    logic              i_sub;
    logic              i_carry;
    logic [DATA_W-1:0] i_data_a;
    logic [DATA_W-1:0] i_data_b;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_sum;
    logic              o_carry;
    logic              o_ovf;
    logic              o_zero;

    modport master (
        output i_valid, i_sub, i_carry, i_data_a, i_data_b, i_ready,
        input  o_ready, o_valid, o_sum, o_carry, o_ovf, o_zero
    );

    modport slave (
        input  i_valid, i_sub, i_carry, i_data_a, i_data_b, i_ready,
        output o_ready, o_valid, o_sum, o_carry, o_ovf, o_zero
    );
endinterface

// File: rtl/add_sub_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor. The operand is cut into N_STAGES
// segments; segment k is resolved in stage k using the registered carry of
// stage k-1. Every stage register carries the whole operand/sum word, so the
// upper operand slices are naturally skewed and the lower sum slices deskewed.
module add_sub_cla_pipe #(
    parameter int DATA_W   = 24,
    parameter int BLK_W    = 4,
    parameter int N_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    add_sub_cla_pipe_if.slave  bus
);
    localparam int SEG_W = (N_STAGES > 0) ? DATA_W / N_STAGES : DATA_W;
    localparam int N_BLK = (BLK_W > 0) ? SEG_W / BLK_W : 1;
    localparam int LAST  = N_STAGES - 1;
    localparam int MSB   = DATA_W - 1;

    if (N_STAGES < 1) begin : g_bad_stages
        $error("add_sub_cla_pipe: N_STAGES must be at least 1");
    end else if (DATA_W % (N_STAGES * BLK_W) != 0) begin : g_bad_width
        $error("add_sub_cla_pipe: DATA_W must be a multiple of N_STAGES*BLK_W");
    end

    // One in-flight operation: valid bit, mode, carry into the next segment,
    // operands (b already conditionally inverted) and the partial sum.
    typedef struct packed {
        logic              v;
        logic              sub;
        logic              c;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] s;
    } stage_t;

    // One segment: BLK_W-bit group P/G blocks, flat lookahead across blocks.
    function automatic logic [SEG_W:0] cla_seg(
        input logic [SEG_W-1:0] a,
        input logic [SEG_W-1:0] b,
        input logic             cin
    );
        logic [SEG_W-1:0] g, p, s;
        logic [N_BLK-1:0] gg, gp;
        logic [N_BLK:0]   bc;
        logic             acc, run;
        g = a & b;
        p = a ^ b;
        s = '0;
        for (int j = 0; j < N_BLK; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < BLK_W; i++) begin
                gg[j] = g[j*BLK_W+i] | (p[j*BLK_W+i] & gg[j]);
                gp[j] = gp[j] & p[j*BLK_W+i];
            end
        end
        bc[0] = cin;
        for (int j = 0; j < N_BLK; j++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int m = j; m >= 0; m--) begin
                acc = acc | (run & gg[m]);
                run = run & gp[m];
            end
            bc[j+1] = acc | (run & cin);
        end
        for (int j = 0; j < N_BLK; j++) begin
            for (int i = 0; i < BLK_W; i++) begin
                acc = 1'b0;
                run = 1'b1;
                for (int m = i - 1; m >= 0; m--) begin
                    acc = acc | (run & g[j*BLK_W+m]);
                    run = run & p[j*BLK_W+m];
                end
                s[j*BLK_W+i] = p[j*BLK_W+i] ^ (acc | (run & bc[j]));
            end
        end
        return {bc[N_BLK], s};
    endfunction

    stage_t st_in  [N_STAGES];
    stage_t st_nxt [N_STAGES];
    logic   en;

    logic              valid_q;
    logic [DATA_W-1:0] sum_q;
    logic              carry_q;
    logic              ovf_q;
    logic              zero_q;

    // A full, unaccepted output freezes the whole pipeline.
    assign en          = ~valid_q | bus.i_ready;
    assign bus.o_ready = en;

    assign st_in[0] = {bus.i_valid, bus.i_sub, bus.i_carry ^ bus.i_sub, bus.i_data_a,
                       bus.i_sub ? ~bus.i_data_b : bus.i_data_b, {DATA_W{1'b0}}};

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        logic [SEG_W:0] seg;
        stage_t         nxt;

        assign seg = cla_seg(st_in[k].a[k*SEG_W +: SEG_W], st_in[k].b[k*SEG_W +: SEG_W], st_in[k].c);

        // Resolve this stage's segment and pass everything else through.
        always_comb begin
            // NOTE: the full default copy first means every bit is assigned on every pass, so no latch is inferred.
            nxt = st_in[k];
            nxt.s[k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
            nxt.c = seg[SEG_W];
        end

        assign st_nxt[k] = nxt;
    end

    if (N_STAGES > 1) begin : g_pipe
        stage_t pipe [N_STAGES-1];

        // Intermediate stage registers, advancing together under the global enable.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                // NOTE: these wide registers are cleared on reset so skew/carry state never leaks into a new op.
                for (int i = 0; i < N_STAGES - 1; i++) pipe[i] <= '0;
            end else if (en) begin
                // NOTE: non-blocking updates let every stage sample its predecessor's old value on the same edge.
                for (int i = 0; i < N_STAGES - 1; i++) pipe[i] <= st_nxt[i];
            end
        end

        for (genvar k = 1; k < N_STAGES; k++) begin : g_link
            assign st_in[k] = pipe[k-1];
        end
    end

    // Output register: result plus flags derived from the op's own operands.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (en) begin
            valid_q <= st_nxt[LAST].v;
            sum_q   <= st_nxt[LAST].s;
            carry_q <= st_nxt[LAST].c ^ st_nxt[LAST].sub;
            ovf_q   <= (st_nxt[LAST].a[MSB] == st_nxt[LAST].b[MSB]) &&
                       (st_nxt[LAST].s[MSB] != st_nxt[LAST].a[MSB]);
            zero_q  <= ~|st_nxt[LAST].s;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_sum   = sum_q;
    assign bus.o_carry = carry_q;
    assign bus.o_ovf   = ovf_q;
    assign bus.o_zero  = zero_q;
endmodule
